// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline front end.
// Holds default widths, the reset PC, the canonical NOP encoding and a small
// alignment helper used by the fetch stage.
package riscv_pkg;

  // Default program counter / memory address width.
  localparam int unsigned IF_PC_WIDTH   = 64;
  // Default instruction width.
  localparam int unsigned IF_INST_WIDTH = 32;

  // PC loaded on reset unless overridden per instance.
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

  // addi x0, x0, 0 -- inserted into IF/ID as a bubble.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // True when the two low address bits describe a 4-byte aligned word.
  function automatic logic is_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage : riscv_pkg

// File: rtl/instruction_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect control in, instruction memory port,
// and the IF/ID pipeline register contents out.
//   slave  : the fetch stage (drives imem_addr and the IF/ID fields)
//   master : the surrounding pipeline / memory model
// Signals:
//   stall, branch_taken, branch_target -- control into fetch
//   imem_addr / imem_inst              -- combinational instruction memory port
//   ifid_pc, ifid_inst, ifid_valid     -- IF/ID register
//   misaligned                         -- one-cycle flag for a rejected redirect
interface instruction_fetch_stage_if
  import riscv_pkg::*;
#(
  parameter int unsigned PC_WIDTH   = IF_PC_WIDTH,
  parameter int unsigned INST_WIDTH = IF_INST_WIDTH
) ();

  logic                  stall;
  logic                  branch_taken;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [INST_WIDTH-1:0] imem_inst;
  logic [PC_WIDTH-1:0]   ifid_pc;
  logic [INST_WIDTH-1:0] ifid_inst;
  logic                  ifid_valid;
  logic                  misaligned;

  modport slave (
    input  stall,
    input  branch_taken,
    input  branch_target,
    input  imem_inst,
    output imem_addr,
    output ifid_pc,
    output ifid_inst,
    output ifid_valid,
    output misaligned
  );

  modport master (
    output stall,
    output branch_taken,
    output branch_target,
    output imem_inst,
    input  imem_addr,
    input  ifid_pc,
    input  ifid_inst,
    input  ifid_valid,
    input  misaligned
  );

endinterface : instruction_fetch_stage_if

// File: rtl/instruction_fetch_stage_pc_register.sv
// pc_register: program counter flop plus next-PC selection.
// Priority: reset -> RESET_PC, redirect_i -> target_i, hold_i -> pc held,
// otherwise pc + 4 (wraps modulo 2^PC_WIDTH).
// Ports:
//   clk, reset  -- clock, asynchronous active-high reset
//   hold_i      -- keep the current PC
//   redirect_i  -- load target_i (wins over hold_i)
//   target_i    -- redirect address
//   pc_o        -- current PC (register output)
module pc_register #(
  parameter int unsigned          PC_WIDTH = 64,
  parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hold_i,
  input  logic                redirect_i,
  input  logic [PC_WIDTH-1:0] target_i,
  output logic [PC_WIDTH-1:0] pc_o
);

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;

  // Next-PC mux; the +4 carry out of the top bit is intentionally dropped.
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (redirect_i) begin
      pc_d = target_i;
    end else if (hold_i) begin
      pc_d = pc_q;
    end
  end

  // PC state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : pc_register

// File: rtl/instruction_fetch_stage.sv
// instruction_fetch_stage: IF stage of the five-stage RISC-V pipeline.
// Drives the instruction memory address straight from the PC, captures the
// returned instruction with its PC into IF/ID, and handles stalls and
// branch/jump redirects (redirect flushes the wrong-path IF/ID slot).
// Optional feature macro: IF_MISALIGN_CHECK_EN -- reject redirects whose
// target is not 4-byte aligned (PC held, IF/ID flushed, misaligned pulses).
// Ports:
//   clk    -- rising-edge clock
//   reset  -- asynchronous active-high reset
//   bus    -- instruction_fetch_stage_if.slave (control, imem port, IF/ID)
module instruction_fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = IF_PC_WIDTH,
  parameter int unsigned         INST_WIDTH = IF_INST_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = PC_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        reset,
  instruction_fetch_stage_if.slave    bus
);

  localparam logic [INST_WIDTH-1:0] NOP = INST_WIDTH'(NOP_INST);

  logic [PC_WIDTH-1:0]   pc;
  logic                  target_ok_c;
  logic                  redirect_c;
  logic                  hold_c;

  logic [PC_WIDTH-1:0]   ifid_pc_q,    ifid_pc_d;
  logic [INST_WIDTH-1:0] ifid_inst_q,  ifid_inst_d;
  logic                  ifid_valid_q, ifid_valid_d;

`ifdef IF_MISALIGN_CHECK_EN
  assign target_ok_c = is_aligned(bus.branch_target[1:0]);
`else
  assign target_ok_c = 1'b1;
`endif

  // A rejected (misaligned) redirect still freezes the PC, hence its place in hold.
  assign redirect_c = bus.branch_taken & target_ok_c;
  assign hold_c     = bus.stall | (bus.branch_taken & ~target_ok_c);

  pc_register #(
    .PC_WIDTH (PC_WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk        (clk),
    .reset      (reset),
    .hold_i     (hold_c),
    .redirect_i (redirect_c),
    .target_i   (bus.branch_target),
    .pc_o       (pc)
  );

  // Memory address is the PC itself, no pipeline register in between.
  assign bus.imem_addr = pc;

  // IF/ID next state: any redirect flushes, stall holds, otherwise capture.
  always_comb begin
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    if (bus.branch_taken) begin
      ifid_pc_d    = '0;
      ifid_inst_d  = NOP;
      ifid_valid_d = 1'b0;
    end else if (!bus.stall) begin
      ifid_pc_d    = pc;
      ifid_inst_d  = bus.imem_inst;
      ifid_valid_d = 1'b1;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc_q    <= '0;
      ifid_inst_q  <= NOP;
      ifid_valid_q <= 1'b0;
    end else begin
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
    end
  end

  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_inst  = ifid_inst_q;
  assign bus.ifid_valid = ifid_valid_q;

`ifdef IF_MISALIGN_CHECK_EN
  logic misaligned_q;
  logic misaligned_d;

  // Flag is re-evaluated every edge, so it lasts one cycle per rejected redirect.
  always_comb begin
    misaligned_d = bus.branch_taken & ~target_ok_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.misaligned = misaligned_q;
`else
  assign bus.misaligned = 1'b0;
`endif

endmodule : instruction_fetch_stage

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed test-plan
// sequence with literal expectations, then randomized stall/redirect traffic
// checked every cycle against a behavioural model, with one asynchronous
// mid-run reset.
module tb_instruction_fetch_stage;
  import riscv_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [31:0] W0 = 32'h0285_3483;
  localparam logic [31:0] W1 = 32'h009A_84B3;
  localparam logic [31:0] W2 = 32'h0014_8493;
  localparam logic [31:0] W3 = 32'h0295_3423;

`ifdef IF_MISALIGN_CHECK_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  instruction_fetch_stage_if bus ();

  instruction_fetch_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: test-plan words at 0..12, hashed elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'd0:   return W0;
      64'd4:   return W1;
      64'd8:   return W2;
      64'd12:  return W3;
      default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
    endcase
  endfunction

  assign bus.imem_inst = mem_word(bus.imem_addr);

  // Behavioural model of the architectural state seen at the outputs.
  logic [63:0] m_pc;
  logic [63:0] m_ipc;
  logic [31:0] m_inst;
  logic        m_valid;
  logic        m_mis;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_pc <= RST_PC; m_ipc <= '0; m_inst <= NOP_INST; m_valid <= 1'b0; m_mis <= 1'b0;
    end else if (bus.branch_taken) begin
      m_ipc <= '0; m_inst <= NOP_INST; m_valid <= 1'b0;
      if (MISALIGN_EN && bus.branch_target[1:0] != 2'b00) begin
        m_mis <= 1'b1;
      end else begin
        m_pc  <= bus.branch_target;
        m_mis <= 1'b0;
      end
    end else begin
      m_mis <= 1'b0;
      if (!bus.stall) begin
        m_ipc <= m_pc; m_inst <= mem_word(m_pc); m_valid <= 1'b1; m_pc <= m_pc + 64'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model imem_addr",  bus.imem_addr,          m_pc);
    chk("model ifid_pc",    bus.ifid_pc,            m_ipc);
    chk("model ifid_inst",  64'(bus.ifid_inst),     64'(m_inst));
    chk("model ifid_valid", 64'(bus.ifid_valid),    64'(m_valid));
    chk("model misaligned", 64'(bus.misaligned),    64'(m_mis));
  end

  // Apply one cycle of inputs just after a falling edge; return after the next one.
  task automatic cycle(input logic s, input logic b, input logic [63:0] t);
    bus.stall = s; bus.branch_taken = b; bus.branch_target = t;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_ifid(input string name, input logic [63:0] pc_e, input logic [31:0] inst_e,
                          input logic v_e);
    chk({name, " pc"},    bus.ifid_pc,           pc_e);
    chk({name, " inst"},  64'(bus.ifid_inst),    64'(inst_e));
    chk({name, " valid"}, 64'(bus.ifid_valid),   64'(v_e));
  endtask

  initial begin
    logic [63:0] tgt;
    bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = '0;
    #1 reset = 1'b1;
    #1;
    chk("reset imem_addr", bus.imem_addr, RST_PC);
    chk_ifid("reset ifid", 64'd0, NOP_INST, 1'b0);
    chk("reset misaligned", 64'(bus.misaligned), 64'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    chk("first fetch addr", bus.imem_addr, 64'd0);

    // Free run from 0.
    cycle(1'b0, 1'b0, '0);
    chk("run addr 4", bus.imem_addr, 64'd4);
    chk_ifid("run ifid0", 64'd0, W0, 1'b1);
    cycle(1'b0, 1'b0, '0);
    chk("run addr 8", bus.imem_addr, 64'd8);
    chk_ifid("run ifid4", 64'd4, W1, 1'b1);

    // Three-cycle stall at pc=8.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0);
      chk("stall addr", bus.imem_addr, 64'd8);
      chk_ifid("stall ifid", 64'd4, W1, 1'b1);
    end
    cycle(1'b0, 1'b0, '0);
    chk("resume addr", bus.imem_addr, 64'd12);
    chk_ifid("resume ifid", 64'd8, W2, 1'b1);

    // Taken branch at pc=12 to 0.
    cycle(1'b0, 1'b1, 64'd0);
    chk("branch addr", bus.imem_addr, 64'd0);
    chk_ifid("branch bubble", 64'd0, NOP_INST, 1'b0);
    cycle(1'b0, 1'b0, '0);
    chk_ifid("branch target ifid", 64'd0, W0, 1'b1);
    cycle(1'b0, 1'b0, '0);

    // Stall and redirect together: redirect wins.
    cycle(1'b1, 1'b1, 64'd4);
    chk("stall+branch addr", bus.imem_addr, 64'd4);
    chk_ifid("stall+branch bubble", 64'd0, NOP_INST, 1'b0);

    // PC wrap at the top of the address space.
    cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap pre addr", bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle(1'b0, 1'b0, '0);
    chk("wrap addr", bus.imem_addr, 64'd0);
    chk("wrap ifid pc", bus.ifid_pc, 64'hFFFF_FFFF_FFFF_FFFC);

    // Redirect to an unaligned target.
    cycle(1'b0, 1'b1, 64'd6);
    if (MISALIGN_EN) begin
      chk("misalign addr held", bus.imem_addr, 64'd0);
      chk("misalign flag", 64'(bus.misaligned), 64'd1);
    end else begin
      chk("unaligned addr loaded", bus.imem_addr, 64'd6);
      chk("misalign flag tied", 64'(bus.misaligned), 64'd0);
    end
    chk_ifid("misalign bubble", 64'd0, NOP_INST, 1'b0);
    cycle(1'b0, 1'b0, '0);
    chk("misalign flag drop", 64'(bus.misaligned), 64'd0);

    // Randomized traffic, with an asynchronous reset in the middle.
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) begin
        bus.stall = 1'b0; bus.branch_taken = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async reset addr", bus.imem_addr, RST_PC);
        chk_ifid("async reset ifid", 64'd0, NOP_INST, 1'b0);
        @(negedge clk);
        #1 reset = 1'b0;
      end
      tgt = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0:       tgt = 64'hFFFF_FFFF_FFFF_FFF0 | (tgt & 64'hF);
        1, 2:    tgt = tgt;
        default: tgt = tgt & ~64'h3;
      endcase
      cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0), tgt);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_instruction_fetch_stage

// File: doc/instruction_fetch_stage.md
# instruction_fetch_stage

Fetch stage of the five-stage RISC-V pipeline. Holds the program counter and drives the byte-addressed instruction memory's 64-bit address. Captures the returned 32-bit little-endian instruction, with its PC, into the IF/ID pipeline register. Handles sequential PC+4 advance, hazard-unit stalls, and branch/jump redirects with a one-slot flush.

## Interface
Parameters:
- PC_WIDTH, 64, program counter and memory address width
- INST_WIDTH, 32, instruction width
- RESET_PC, 64'h0, PC value loaded on reset

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- stall  in  1  hazard unit: hold PC and IF/ID contents
- branch_taken  in  1  EX stage: redirect fetch this cycle
- branch_target  in  PC_WIDTH  redirect address, valid when branch_taken=1
- imem_addr  out  PC_WIDTH  address to instruction memory (combinational, equals current PC)
- imem_inst  in  INST_WIDTH  instruction from memory (combinational read of imem_addr)
- ifid_pc  out  PC_WIDTH  PC of the instruction held in IF/ID
- ifid_inst  out  INST_WIDTH  instruction held in IF/ID
- ifid_valid  out  1  IF/ID holds a real instruction (0 = bubble)
- misaligned  out  1  redirect target not 4-byte aligned (see Configuration)

## Operation
- Reset values: pc=RESET_PC, ifid_pc=0, ifid_inst=NOP (32'h00000013), ifid_valid=0, misaligned=0.
- imem_addr = pc at all times, with no register between them.
- Next-PC priority, highest first:
  - reset → RESET_PC.
  - branch_taken → branch_target. Redirect overrides stall.
  - stall → pc held.
  - otherwise → pc+4.
- PC arithmetic is modulo 2^PC_WIDTH: pc = 64'hFFFF_FFFF_FFFF_FFFC advances to 0 with no flag.
- IF/ID update, same priority order:
  - branch_taken → ifid_valid=0, ifid_inst=NOP, ifid_pc=0 (flush of the wrong-path slot).
  - stall → all IF/ID fields held.
  - otherwise → ifid_pc=pc, ifid_inst=imem_inst, ifid_valid=1.
- Stall with branch_taken in the same cycle is treated as a redirect: the PC is loaded and IF/ID is flushed.
- Reset asserted mid-operation clears the PC and IF/ID immediately, without waiting for a clock edge. The first fetch after reset deasserts is RESET_PC.

## Timing
- Fetch latency is one cycle. If PC=A during cycle n, IF/ID shows {A, mem[A]} after edge n+1.
- Redirect: branch_taken=1 in cycle n with target T gives the following:
  - edge n+1: pc=T and IF/ID is a bubble.
  - edge n+2: IF/ID={T, mem[T]}, valid=1.
  - Branch penalty is one bubble as seen from IF/ID.
- Stall for k cycles: pc and IF/ID are frozen for k edges. Fetch resumes on the first edge after stall drops, and no instruction is lost or duplicated.
- The input branch_target is sampled only on edges where branch_taken=1.

## Configuration
- IF_MISALIGN_CHECK_EN defined:
  - A redirect with branch_target[1:0]≠0 does not load the PC; pc holds its value.
  - IF/ID is flushed to a bubble.
  - misaligned pulses high for exactly one cycle, registered and asserted after the redirect edge.
  - An aligned redirect behaves normally.
- IF_MISALIGN_CHECK_EN undefined: branch_target is loaded as-is, and misaligned is tied to 0.

## Structure
- Shared package riscv_pkg holds:
  - NOP_INST = 32'h00000013
  - PC_WIDTH and INST_WIDTH defaults
  - DEFAULT_RESET_PC
- Sub-module pc_register: the PC flop plus next-PC mux (reset/redirect/stall/+4).
- The top level adds the IF/ID register and the optional misalignment check.

## Test plan
- Reset then free-run, with memory words 0x02853483, 0x009A84B3, 0x00148493, 0x02953423 at 0/4/8/12 → imem_addr follows 0,4,8,12. IF/ID shows each word one cycle later, valid=1 from the second edge.
- Stall held 3 cycles while pc=8 → pc stays 8 and IF/ID stays {4, 0x009A84B3}. After release, IF/ID gets {8, 0x00148493}.
- branch_taken with target 0 while pc=12 → next cycle pc=0, ifid_valid=0, ifid_inst=0x00000013. The cycle after, IF/ID={0, 0x02853483}.
- stall and branch_taken together, target 4 → redirect wins: pc=4 and IF/ID flushed.
- pc forced to 64'hFFFF_FFFF_FFFF_FFFC, one free edge → pc=0.
- With IF_MISALIGN_CHECK_EN: redirect to 6 → pc unchanged, bubble in IF/ID, misaligned high for one cycle. Without the macro: pc=6 and misaligned stays 0.
